if_id_reg: RTL and testbench

IF_ID_REG -- requirements
Module: if_id_reg

---
 rtl/if_id_reg_if.sv | 42 ++++
 rtl/if_id_reg.sv | 105 ++++++++++
 tb/tb_if_id_reg.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/if_id_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg_if
// Brief    : Fetch/decode handshake bundle for the IF/ID instruction buffer.
//            stall_cycles exists only when IF_ID_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface if_id_reg_if;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus8;
`ifdef IF_ID_PERF_EN
    logic [15:0] stall_cycles;
`endif

    // Environment side: drives fetch and decode-ready, observes the buffer.
    modport master (
        output if_valid, if_instr, if_pc, flush, id_ready,
        input  if_ready, id_valid, id_instr, id_pc, id_pc_plus8
`ifdef IF_ID_PERF_EN
        , input stall_cycles
`endif
    );

    // Buffer side.
    modport slave (
        input  if_valid, if_instr, if_pc, flush, id_ready,
        output if_ready, id_valid, id_instr, id_pc, id_pc_plus8
`ifdef IF_ID_PERF_EN
        , output stall_cycles
`endif
    );
endinterface

`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : if_id_reg
// Brief    : 2-entry in-order IF/ID buffer of {instr, pc} with flush and an
//            ARM-style PC+8 view. Optional stall counter under IF_ID_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_reg (
    input  logic       clk,
    input  logic       reset,
    if_id_reg_if.slave bus
);
    localparam int unsigned DEPTH        = 2;
    localparam logic [1:0]  c_COUNT_FULL = 2'd2;
    localparam logic [31:0] c_PC_OFFSET  = 32'd8;

    logic [1:0]  r_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [31:0] r_instr [DEPTH];
    logic [31:0] r_pc    [DEPTH];

    logic        w_if_ready;
    logic        w_id_valid;
    logic        w_push;
    logic        w_pop;
    logic        w_wr_en;
    logic [31:0] w_head_instr;
    logic [31:0] w_head_pc;

    // Ready comes only from registered occupancy, so no ready->ready path.
    assign w_if_ready = (r_count != c_COUNT_FULL);
    assign w_id_valid = (r_count != 2'd0);
    assign w_push     = bus.if_valid & w_if_ready;
    assign w_pop      = w_id_valid & bus.id_ready;
    assign w_wr_en    = w_push & ~bus.flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else if (bus.flush) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            localparam logic c_IDX = 1'(gi);
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_instr[gi] <= 32'd0;
                    r_pc[gi]    <= 32'd0;
                end else if (w_wr_en && (r_wr_ptr == c_IDX)) begin
                    r_instr[gi] <= bus.if_instr;
                    r_pc[gi]    <= bus.if_pc;
                end
            end
        end
    endgenerate

    // Stale storage is masked so decode never sees leftover words.
    assign w_head_instr = w_id_valid ? r_instr[r_rd_ptr] : 32'd0;
    assign w_head_pc    = w_id_valid ? r_pc[r_rd_ptr]    : 32'd0;

    assign bus.if_ready    = w_if_ready;
    assign bus.id_valid    = w_id_valid;
    assign bus.id_instr    = w_head_instr;
    assign bus.id_pc       = w_head_pc;
    assign bus.id_pc_plus8 = w_id_valid ? (w_head_pc + c_PC_OFFSET) : 32'd0;

`ifdef IF_ID_PERF_EN
    logic [15:0] r_stall_cycles;

    // Saturating; flush intentionally leaves it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 16'd0;
        end else if (w_id_valid && !bus.id_ready && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_reg
// Brief    : Directed vector table plus ordering and counter sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_reg;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    if_id_reg_if bus ();

    if_id_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        idr;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [31:0] e_pc8;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    vec_t vecs[$];
    ent_t model[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic v,
                         input logic [31:0] ins, input logic [31:0] p, input logic idr);
        reset        = r;
        bus.flush    = f;
        bus.if_valid = v;
        bus.if_instr = ins;
        bus.if_pc    = p;
        bus.id_ready = idr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] A = 32'hAAAA0001, B = 32'hBBBB0002, C = 32'hCCCC0003;
    localparam logic [31:0] NOP = 32'hE1A00000;

    initial begin
        errors = 0;
        checks = 0;
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        tick();

`ifdef IF_ID_PERF_EN
        chk("stall_reset", {16'd0, bus.stall_cycles}, 32'd0);
`endif

        //            rst   fl    vld   instr          pc             idr   rdy   vld   e_instr        e_pc           e_pc8
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b0, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'hE3A01005, 32'h100,       1'b1, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b1, 1'b1, 32'hE3A01005, 32'h100,       32'h108});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        // back-pressure A, B, C
        vecs.push_back('{1'b0, 1'b0, 1'b1, A,            32'h200,       1'b0, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, B,            32'h204,       1'b0, 1'b1, 1'b1, A,            32'h200,       32'h208});
        vecs.push_back('{1'b0, 1'b0, 1'b1, C,            32'h208,       1'b0, 1'b0, 1'b1, A,            32'h200,       32'h208});
        vecs.push_back('{1'b0, 1'b0, 1'b1, C,            32'h208,       1'b1, 1'b0, 1'b1, A,            32'h200,       32'h208});
        vecs.push_back('{1'b0, 1'b0, 1'b1, C,            32'h208,       1'b1, 1'b1, 1'b1, B,            32'h204,       32'h20C});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b1, 1'b1, C,            32'h208,       32'h210});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        // flush while full with a push offered
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h11110001, 32'h300,       1'b0, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h22220002, 32'h304,       1'b0, 1'b1, 1'b1, 32'h11110001, 32'h300,       32'h308});
        vecs.push_back('{1'b0, 1'b1, 1'b1, NOP,          32'h308,       1'b0, 1'b0, 1'b1, 32'h11110001, 32'h300,       32'h308});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        // flush with one held entry and an accepted push plus pop
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h33330003, 32'h400,       1'b0, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, NOP,          32'h404,       1'b1, 1'b1, 1'b1, 32'h33330003, 32'h400,       32'h408});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        // PC wrap
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h12345678, 32'hFFFFFFFC,  1'b1, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b1, 1'b1, 32'h12345678, 32'hFFFFFFFC,  32'h4});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        // reset while full, with push and pop offered
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h44440004, 32'h500,       1'b0, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h55550005, 32'h504,       1'b0, 1'b1, 1'b1, 32'h44440004, 32'h500,       32'h508});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 32'h77770007, 32'h508,       1'b1, 1'b0, 1'b1, 32'h44440004, 32'h500,       32'h508});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b0, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 32'h66660006, 32'h600,       1'b0, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b1, 1'b1, 32'h66660006, 32'h600,       32'h608});
        vecs.push_back('{1'b0, 1'b0, 1'b0, 32'd0,        32'd0,         1'b1, 1'b1, 1'b0, 32'd0,        32'd0,         32'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].flush, vecs[i].vld, vecs[i].instr, vecs[i].pc, vecs[i].idr);
            #1;
            chk($sformatf("v%0d_if_ready", i), {31'd0, bus.if_ready}, {31'd0, vecs[i].e_rdy});
            chk($sformatf("v%0d_id_valid", i), {31'd0, bus.id_valid}, {31'd0, vecs[i].e_vld});
            chk($sformatf("v%0d_id_instr", i), bus.id_instr,    vecs[i].e_instr);
            chk($sformatf("v%0d_id_pc", i),    bus.id_pc,       vecs[i].e_pc);
            chk($sformatf("v%0d_id_pc8", i),   bus.id_pc_plus8, vecs[i].e_pc8);
            tick();
        end

        // Ordering sequence against a queue model with irregular handshakes.
        begin
            int n;
            logic v;
            logic r;
            logic do_push;
            logic do_pop;
            n = 0;
            model.delete();
            for (int i = 0; i < 48; i++) begin
                v = (i % 4) != 1;
                r = (i % 3) != 0;
                drive(1'b0, 1'b0, v, 32'hA0000000 + n, 32'h1000 + 4 * n, r);
                #1;
                chk($sformatf("ord%0d_if_ready", i), {31'd0, bus.if_ready},
                    {31'd0, model.size() < 2});
                chk($sformatf("ord%0d_id_valid", i), {31'd0, bus.id_valid},
                    {31'd0, model.size() > 0});
                if (model.size() > 0) begin
                    chk($sformatf("ord%0d_id_instr", i), bus.id_instr, model[0].instr);
                    chk($sformatf("ord%0d_id_pc", i),    bus.id_pc,    model[0].pc);
                end
                do_pop  = (model.size() > 0) && r;
                do_push = v && (model.size() < 2);
                if (do_pop)  void'(model.pop_front());
                if (do_push) begin
                    model.push_back('{32'hA0000000 + n, 32'h1000 + 4 * n});
                    n++;
                end
                tick();
            end
            drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
            tick();
            tick();
            chk("ord_drained", {31'd0, bus.id_valid}, 32'd0);
        end

`ifdef IF_ID_PERF_EN
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("stall_after_reset", {16'd0, bus.stall_cycles}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 32'h88880008, 32'h700, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk("stall_count10", {16'd0, bus.stall_cycles}, 32'd10);
        for (int i = 0; i < 69990; i++) tick();
        chk("stall_saturated", {16'd0, bus.stall_cycles}, 32'h0000FFFF);
        for (int i = 0; i < 5; i++) tick();
        chk("stall_holds", {16'd0, bus.stall_cycles}, 32'h0000FFFF);
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("stall_after_flush", {16'd0, bus.stall_cycles}, 32'h0000FFFF);
        chk("flush_valid", {31'd0, bus.id_valid}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        #1;
        chk("stall_cleared", {16'd0, bus.stall_cycles}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

`default_nettype wire
